layer_mac_scheduler: RTL and testbench
======================================

LAYER_MAC_SCHEDULER -- requirements
Module: layer_mac_scheduler

Interface
REQ-001 SHALL have parameter NUMBER_INPUTS96, default 6, number of input activations per inference.
REQ-002 SHALL have parameter NUMBER_NEURONS96, default 4, number of neurons sequenced through the shared MAC.
REQ-003 SHALL have parameter TIMEOUT96, default 64, maximum WAIT cycles per MAC operation.
REQ-004 SHALL have parameter RELU96, default 1; 1 = apply ReLU on store, 0 = pass-through.
REQ-005 SHALL have port clk96  input  1  single clock, all state on rising edge.
REQ-006 SHALL have port rst96  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port start96  input  1  begin one layer evaluation.
REQ-008 SHALL have port in_values96  input  NUMBER_INPUTS96x16  fp16 activations, sampled with start96.
REQ-009 SHALL have port w_addr96  output  AW=$clog2((NUMBER_INPUTS96+1)*NUMBER_NEURONS96)  weight RAM address.
REQ-010 SHALL have port w_data96  input  16  fp16 weight, one-cycle synchronous read latency.
REQ-011 SHALL have ports mac_a96, mac_b96, mac_c96  output  16 each  MAC operands a*b+c.
REQ-012 SHALL have port mac_valid96  output  1  operand-valid strobe to the external fp16 FMA.
REQ-013 SHALL have ports mac_res_valid96  input  1, and mac_res96  input  16, for the FMA result.
REQ-014 SHALL have ports busy96  output  1, done96  output  1, err96  output  1, result96  output  NUMBER_NEURONS96x16.

Function
REQ-015 SHALL implement states IDLE, FETCH, ISSUE, WAIT, ACT, DONE.
REQ-016 IDLE: start96=1 latches in_values96 into an internal buffer, with element 0 = 16'h3C00 (bias 1.0) and elements 1..N = inputs; clears neuron index j, input index i, accumulator, err96; enters FETCH.
REQ-017 start96 SHALL be ignored in every state other than IDLE.
REQ-018 FETCH (1 cycle): w_addr96 = i*NUMBER_NEURONS96 + j, registered; next ISSUE.
REQ-019 ISSUE (1 cycle): mac_valid96=1, mac_a96=buffer[i], mac_b96=w_data96 (combinational), mac_c96=accumulator; next WAIT.
REQ-020 mac_valid96 SHALL be 1 only in ISSUE, so at most one MAC operation is outstanding.
REQ-021 WAIT: on mac_res_valid96=1, accumulator <= mac_res96; if i==NUMBER_INPUTS96 go ACT, else i++ and go FETCH.
REQ-022 mac_res_valid96 outside WAIT SHALL be ignored.
REQ-023 WAIT timeout: SHALL count WAIT cycles; on the TIMEOUT96-th cycle without mac_res_valid96, set err96=1 (sticky until next accepted start), go IDLE, no done96, result96 unchanged.
REQ-024 ACT (1 cycle): result96[j] <= (RELU96 && accumulator[15]) ? 16'h0000 : accumulator; -0.0 (16'h8000) stores as 16'h0000.
REQ-025 ACT: accumulator <= 0 and i <= 0; if j==NUMBER_NEURONS96-1 go DONE, else j++ and go FETCH.
REQ-026 DONE (1 cycle): done96=1 for exactly one cycle; next IDLE.
REQ-027 busy96 SHALL be 1 in all states except IDLE.
REQ-028 result96 SHALL hold its values until overwritten by a later ACT; entries not yet reached keep prior values.
REQ-029 Cycle count per MAC step SHALL be 2+L for FMA latency L.
REQ-030 Layer latency from the start edge to the done96 cycle SHALL be NUMBER_NEURONS96*((NUMBER_INPUTS96+1)*(2+L)+1)+1.

Reset
REQ-031 rst96=1 SHALL immediately force IDLE, regardless of clock, including mid-operation.
REQ-032 On reset, w_addr96, mac_a96, mac_b96, mac_c96, mac_valid96, busy96, done96, err96, result96, accumulator and all indices SHALL be 0.
REQ-033 An in-flight FMA result arriving after reset SHALL be ignored per REQ-022.

Verification
REQ-034 Stub FMA with L=3; all inputs 3C00; all weights 3C00; start -> every result96 entry = 4700 (7.0); done96 pulses at the 145th cycle after the start edge; mac_valid96 counted 28 times.
REQ-035 All weights BC00 with inputs 3C00 -> each sum is -7.0 (C700); result96 = 0000 with RELU96=1, and C700 with RELU96=0.
REQ-036 Stub never asserts mac_res_valid96 -> err96=1 after 64 WAIT cycles; busy96 falls; no done96; result96 unchanged; next start clears err96.
REQ-037 Assert rst96 during WAIT of neuron 2 -> same-cycle IDLE with all outputs 0; a late mac_res_valid96 is ignored; a fresh start gives correct results.
REQ-038 Pulse start96 while busy with different in_values96 -> no effect; results match the originally latched inputs; w_addr96 sequence is 0,4,8,...,24,1,5,...

Source files
------------

// File: rtl/layer_mac_scheduler.sv
// rtl/layer_mac_scheduler.sv - one fully connected layer sequenced through a single shared fp16 MAC
//
// Ports:
//   clk96, rst96           clock; asynchronous active-high reset
//   start96, in_values96   launch one evaluation; activations are latched with start96
//   w_addr96, w_data96     weight RAM address (registered) / read data (1-cycle latency)
//   mac_a96/b96/c96        FMA operands a*b+c, qualified by mac_valid96
//   mac_res_valid96/res96  FMA result return
//   busy96, done96, err96  status: not idle / one-cycle completion pulse / sticky timeout
//   result96               per-neuron outputs, neuron j at bits [j*16 +: 16]
//
// Weight layout: address = i*NUMBER_NEURONS96 + j, where i = 0 is the bias weight
// (multiplied by a constant 1.0 activation) and i = 1..NUMBER_INPUTS96 are the inputs.

module layer_mac_scheduler #(
  parameter int NUMBER_INPUTS96  = 6,
  parameter int NUMBER_NEURONS96 = 4,
  parameter int TIMEOUT96        = 64,
  parameter int RELU96           = 1,
  localparam int AW = $clog2((NUMBER_INPUTS96 + 1) * NUMBER_NEURONS96)
) (
  input  logic                           clk96,
  input  logic                           rst96,
  input  logic                           start96,
  input  logic [NUMBER_INPUTS96*16-1:0]  in_values96,
  output logic [AW-1:0]                  w_addr96,
  input  logic [15:0]                    w_data96,
  output logic [15:0]                    mac_a96,
  output logic [15:0]                    mac_b96,
  output logic [15:0]                    mac_c96,
  output logic                           mac_valid96,
  input  logic                           mac_res_valid96,
  input  logic [15:0]                    mac_res96,
  output logic                           busy96,
  output logic                           done96,
  output logic                           err96,
  output logic [NUMBER_NEURONS96*16-1:0] result96
);

  localparam int IW = $clog2(NUMBER_INPUTS96 + 1);
  localparam int JW = $clog2(NUMBER_NEURONS96 + 1);
  localparam int TW = $clog2(TIMEOUT96 + 1);

  localparam logic [IW-1:0] I_LAST = IW'(NUMBER_INPUTS96);
  localparam logic [JW-1:0] J_LAST = JW'(NUMBER_NEURONS96 - 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT96 - 1);

  localparam logic [15:0] FP16_ONE = 16'h3C00;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    ISSUE = 3'd2,
    WAIT  = 3'd3,
    ACT   = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t                          state_q, state_d;
  logic [15:0]                     buf_q [0:NUMBER_INPUTS96];
  logic [15:0]                     buf_d [0:NUMBER_INPUTS96];
  logic [IW-1:0]                   i_q, i_d;
  logic [JW-1:0]                   j_q, j_d;
  logic [15:0]                     acc_q, acc_d;
  logic                            err_q, err_d;
  logic [NUMBER_NEURONS96*16-1:0]  result_q, result_d;
  logic [AW-1:0]                   w_addr_q, w_addr_d;
  logic [TW-1:0]                   wait_cnt_q, wait_cnt_d;

  logic [IW-1:0]                   i_inc;
  logic [JW-1:0]                   j_inc;
  logic [15:0]                     store_val;

  // Weight address for (input i, neuron j).
  function automatic logic [AW-1:0] weight_addr(input logic [IW-1:0] i, input logic [JW-1:0] j);
    logic [31:0] t;
    t = 32'(i) * 32'(NUMBER_NEURONS96) + 32'(j);
    return t[AW-1:0];
  endfunction

  assign i_inc = i_q + 1'b1;
  assign j_inc = j_q + 1'b1;

  // Negative sums (including -0.0) clamp to +0.0 when ReLU is enabled.
  assign store_val = ((RELU96 != 0) && acc_q[15]) ? 16'h0000 : acc_q;

  always_comb begin
    state_d     = state_q;
    buf_d       = buf_q;
    i_d         = i_q;
    j_d         = j_q;
    acc_d       = acc_q;
    err_d       = err_q;
    result_d    = result_q;
    w_addr_d    = w_addr_q;
    wait_cnt_d  = wait_cnt_q;
    mac_valid96 = 1'b0;
    mac_a96     = 16'h0000;
    mac_b96     = 16'h0000;
    mac_c96     = 16'h0000;

    case (state_q)
      IDLE: begin
        if (start96) begin
          buf_d[0] = FP16_ONE;
          for (int k = 0; k < NUMBER_INPUTS96; k++) begin
            buf_d[k+1] = in_values96[k*16 +: 16];
          end
          i_d        = '0;
          j_d        = '0;
          acc_d      = 16'h0000;
          err_d      = 1'b0;
          wait_cnt_d = '0;
          w_addr_d   = weight_addr('0, '0);
          state_d    = FETCH;
        end
      end

      // The address was registered on entry, so the RAM samples it during
      // this cycle and the weight is on w_data96 throughout ISSUE.
      FETCH: begin
        state_d = ISSUE;
      end

      ISSUE: begin
        mac_valid96 = 1'b1;
        mac_a96     = buf_q[i_q];
        mac_b96     = w_data96;
        mac_c96     = acc_q;
        wait_cnt_d  = '0;
        state_d     = WAIT;
      end

      WAIT: begin
        if (mac_res_valid96) begin
          acc_d = mac_res96;
          if (i_q == I_LAST) begin
            state_d = ACT;
          end else begin
            i_d      = i_inc;
            w_addr_d = weight_addr(i_inc, j_q);
            state_d  = FETCH;
          end
        end else if (wait_cnt_q == T_LAST) begin
          // Abandon the layer; result96 keeps whatever was already stored.
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end

      ACT: begin
        for (int n = 0; n < NUMBER_NEURONS96; n++) begin
          if (j_q == JW'(n)) begin
            result_d[n*16 +: 16] = store_val;
          end
        end
        acc_d = 16'h0000;
        i_d   = '0;
        if (j_q == J_LAST) begin
          state_d = DONE;
        end else begin
          j_d      = j_inc;
          w_addr_d = weight_addr('0, j_inc);
          state_d  = FETCH;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk96 or posedge rst96) begin
    if (rst96) begin
      state_q    <= IDLE;
      for (int k = 0; k <= NUMBER_INPUTS96; k++) begin
        buf_q[k] <= 16'h0000;
      end
      i_q        <= '0;
      j_q        <= '0;
      acc_q      <= 16'h0000;
      err_q      <= 1'b0;
      result_q   <= '0;
      w_addr_q   <= '0;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      buf_q      <= buf_d;
      i_q        <= i_d;
      j_q        <= j_d;
      acc_q      <= acc_d;
      err_q      <= err_d;
      result_q   <= result_d;
      w_addr_q   <= w_addr_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  assign w_addr96 = w_addr_q;
  assign busy96   = (state_q != IDLE);
  assign done96   = (state_q == DONE);
  assign err96    = err_q;
  assign result96 = result_q;

endmodule

// File: tb/tb_layer_mac_scheduler.sv
// tb/tb_layer_mac_scheduler.sv - directed self-checking bench for layer_mac_scheduler

module tb_layer_mac_scheduler;

  localparam int NI = 6;
  localparam int NN = 4;
  localparam int AW = 5;
  localparam int L  = 3;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               start = 1'b0;
  logic [NI*16-1:0]   in_values = '0;
  logic [15:0]        w_data = 16'h0000;
  logic               mac_res_valid;
  logic [15:0]        mac_res = 16'h0000;

  logic [AW-1:0]      w_addr;
  logic [15:0]        mac_a, mac_b, mac_c;
  logic               mac_valid, busy, done, err;
  logic [NN*16-1:0]   result;

  logic [AW-1:0]      w_addr_nr;
  logic [15:0]        mac_a_nr, mac_b_nr, mac_c_nr;
  logic               mac_valid_nr, busy_nr, done_nr, err_nr;
  logic [NN*16-1:0]   result_nr;

  always #5 clk = ~clk;

  layer_mac_scheduler #(
    .NUMBER_INPUTS96(NI), .NUMBER_NEURONS96(NN), .TIMEOUT96(64), .RELU96(1)
  ) u_dut (
    .clk96(clk), .rst96(rst), .start96(start), .in_values96(in_values),
    .w_addr96(w_addr), .w_data96(w_data),
    .mac_a96(mac_a), .mac_b96(mac_b), .mac_c96(mac_c), .mac_valid96(mac_valid),
    .mac_res_valid96(mac_res_valid), .mac_res96(mac_res),
    .busy96(busy), .done96(done), .err96(err), .result96(result)
  );

  // Non-ReLU twin runs in lockstep on the same weights and FMA stub.
  layer_mac_scheduler #(
    .NUMBER_INPUTS96(NI), .NUMBER_NEURONS96(NN), .TIMEOUT96(64), .RELU96(0)
  ) u_dut_nr (
    .clk96(clk), .rst96(rst), .start96(start), .in_values96(in_values),
    .w_addr96(w_addr_nr), .w_data96(w_data),
    .mac_a96(mac_a_nr), .mac_b96(mac_b_nr), .mac_c96(mac_c_nr), .mac_valid96(mac_valid_nr),
    .mac_res_valid96(mac_res_valid), .mac_res96(mac_res),
    .busy96(busy_nr), .done96(done_nr), .err96(err_nr), .result96(result_nr)
  );

  // fp16 helpers, exact for small integers only
  function automatic int h2i(input logic [15:0] h);
    int e, m, v;
    if (h[14:10] == 5'd0) return 0;
    e = int'(h[14:10]) - 15;
    m = int'({1'b1, h[9:0]});
    if (e >= 10) v = m <<< (e - 10);
    else if (e >= 0) v = m >>> (10 - e);
    else v = 0;
    return h[15] ? -v : v;
  endfunction

  function automatic logic [15:0] i2h(input int v);
    int a, p;
    logic [15:0] r;
    if (v == 0) return 16'h0000;
    a = (v < 0) ? -v : v;
    p = 0;
    for (int b = 0; b < 11; b++) if (a >= (1 << b)) p = b;
    r[15]    = (v < 0);
    r[14:10] = 5'(p + 15);
    r[9:0]   = 10'((a << (10 - p)) & 1023);
    return r;
  endfunction

  // weight RAM, one-cycle synchronous read
  logic [15:0] wmem [0:31];
  always @(posedge clk) w_data <= wmem[w_addr];

  // FMA stub with latency L: valid arrives on the L-th WAIT cycle
  logic [L-1:0] sr = '0;
  logic         stub_en = 1'b1;
  always @(posedge clk) begin
    sr <= {sr[L-2:0], mac_valid};
    if (mac_valid) mac_res <= i2h(h2i(mac_a) * h2i(mac_b) + h2i(mac_c));
  end
  assign mac_res_valid = sr[L-1] & stub_en;

  // monitors
  int          mv_cnt = 0;
  int          done_cnt = 0;
  logic [AW-1:0] addr_log [0:511];
  always @(posedge clk) begin
    if (mac_valid) begin
      if (mv_cnt < 512) addr_log[mv_cnt] <= w_addr;
      mv_cnt <= mv_cnt + 1;
    end
    if (done) done_cnt <= done_cnt + 1;
  end

  int n_asserts = 0;
  int n_fail = 0;
  int mv_base;
  int done_base;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Leaves the bench at cycle 1 (first FETCH), #1 after the start edge.
  task automatic do_start(input logic [NI*16-1:0] vals);
    @(negedge clk);
    in_values = vals;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    mv_base = mv_cnt;
    done_base = done_cnt;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int c;
    c = 0;
    while (!done && c < budget) begin
      @(posedge clk);
      #1;
      c++;
    end
    check(tag, {63'd0, done}, 64'd1);
    cyc(1);
  endtask

  task automatic fill_w(input logic [15:0] w0, input logic [15:0] w1, input logic [15:0] w2, input logic [15:0] w3);
    for (int a = 0; a < 32; a++) begin
      case (a % NN)
        0: wmem[a] = w0;
        1: wmem[a] = w1;
        2: wmem[a] = w2;
        default: wmem[a] = w3;
      endcase
    end
  endtask

  localparam logic [NI*16-1:0] ONES = {6{16'h3C00}};
  localparam logic [NI*16-1:0] TWOS = {6{16'h4000}};
  localparam logic [NI*16-1:0] RAMP = {16'h4600, 16'h4500, 16'h4400, 16'h4200, 16'h4000, 16'h3C00};

  initial begin
    fill_w(16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00);

    // reset state
    cyc(3);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_err", {63'd0, err}, 64'd0);
    check("rst_mac_valid", {63'd0, mac_valid}, 64'd0);
    check("rst_w_addr", {59'd0, w_addr}, 64'd0);
    check("rst_result", result, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    cyc(2);
    check("idle_busy", {63'd0, busy}, 64'd0);

    // all ones, start pulse while busy must be ignored
    do_start(ONES);
    check("c1_busy", {63'd0, busy}, 64'd1);
    check("c1_w_addr", {59'd0, w_addr}, 64'd0);
    check("c1_mac_valid", {63'd0, mac_valid}, 64'd0);
    cyc(1);
    check("c2_mac_valid", {63'd0, mac_valid}, 64'd1);
    check("c2_mac_a", {48'd0, mac_a}, 64'h3C00);
    check("c2_mac_b", {48'd0, mac_b}, 64'h3C00);
    check("c2_mac_c", {48'd0, mac_c}, 64'h0000);
    cyc(7);
    @(negedge clk);
    in_values = TWOS;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    cyc(134);
    check("c144_done", {63'd0, done}, 64'd0);
    cyc(1);
    check("c145_done", {63'd0, done}, 64'd1);
    check("c145_busy", {63'd0, busy}, 64'd1);
    cyc(1);
    check("c146_done", {63'd0, done}, 64'd0);
    check("c146_busy", {63'd0, busy}, 64'd0);
    check("ones_result", result, 64'h4700_4700_4700_4700);
    check("ones_mac_count", 64'(mv_cnt - mv_base), 64'd28);
    check("ones_done_count", 64'(done_cnt - done_base), 64'd1);
    for (int k = 0; k < 28; k++) begin
      check($sformatf("w_addr_seq[%0d]", k), {59'd0, addr_log[mv_base + k]}, 64'((k % 7) * NN + k / 7));
    end

    // negative weights: ReLU clamps, pass-through keeps -7.0
    fill_w(16'hBC00, 16'hBC00, 16'hBC00, 16'hBC00);
    do_start(ONES);
    wait_done("neg_done", 200);
    check("neg_result_relu", result, 64'h0000_0000_0000_0000);
    check("neg_result_nr", result_nr, 64'hC700_C700_C700_C700);

    // ramp inputs 1..6 with per-neuron weights 1, -1, 2, 0
    fill_w(16'h3C00, 16'hBC00, 16'h4000, 16'h0000);
    do_start(RAMP);
    cyc(1);
    check("ramp_c2_mac_a", {48'd0, mac_a}, 64'h3C00);
    wait_done("ramp_done", 200);
    check("ramp_result_relu", result, 64'h0000_5180_0000_4D80);
    check("ramp_result_nr", result_nr, 64'h0000_5180_CD80_4D80);

    // FMA never answers: timeout on the 64th WAIT cycle
    stub_en = 1'b0;
    do_start(ONES);
    cyc(65);
    check("to_c66_busy", {63'd0, busy}, 64'd1);
    check("to_c66_err", {63'd0, err}, 64'd0);
    cyc(1);
    check("to_c67_busy", {63'd0, busy}, 64'd0);
    check("to_c67_err", {63'd1, err} & 64'd1, 64'd1);
    cyc(3);
    check("to_err_sticky", {63'd0, err}, 64'd1);
    check("to_no_done", 64'(done_cnt - done_base), 64'd0);
    check("to_result_kept", result, 64'h0000_5180_0000_4D80);
    stub_en = 1'b1;

    // fresh start clears err; reset during neuron 2 WAIT
    fill_w(16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00);
    do_start(ONES);
    check("restart_err_clear", {63'd0, err}, 64'd0);
    cyc(74);
    check("n2_wait_busy", {63'd0, busy}, 64'd1);
    check("n2_partial_result", result, 64'h0000_5180_4700_4700);
    rst = 1'b1;
    #1;
    check("arst_busy", {63'd0, busy}, 64'd0);
    check("arst_mac_valid", {63'd0, mac_valid}, 64'd0);
    check("arst_w_addr", {59'd0, w_addr}, 64'd0);
    check("arst_result", result, 64'd0);
    check("arst_err", {63'd0, err}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    cyc(5);
    check("late_res_busy", {63'd0, busy}, 64'd0);
    check("late_res_result", result, 64'd0);
    do_start(ONES);
    wait_done("fresh_done", 200);
    check("fresh_result", result, 64'h4700_4700_4700_4700);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed no finish expected finish");
    $fatal(1, "simulation time limit reached");
  end

endmodule
